// File: rtl/sd_pkg.sv
// Shared definitions for the sd_card request arbiter: FSM state encoding
// and the hard upper limit on the number of requesters.
package sd_pkg;

  localparam int SD_MAX_REQ = 8;

  typedef enum logic [1:0] {
    SD_ARB_IDLE    = 2'd0,
    SD_ARB_ACTIVE  = 2'd1,
    SD_ARB_RELEASE = 2'd2
  } sd_arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the pending vector starting
// one past the last winner, wrapping modulo N, and returns the first hit.
import sd_pkg::*;

module rr_pick #(
  parameter int N = 4
) (
  input  logic [SD_MAX_REQ-1:0] pend,
  input  logic [2:0]            last,
  output logic                  valid,
  output logic [2:0]            idx
);

  logic [3:0] sum;
  logic [2:0] cand;

  // Walk candidates last+1 .. last+N (mod N); the first pending one wins
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    sum   = 4'd0;
    cand  = 3'd0;
    for (int k = 1; k <= SD_MAX_REQ; k++) begin
      if (k <= N) begin
        sum = {1'b0, last} + 4'(k);
        if (sum >= 4'(N)) sum = sum - 4'(N);
        cand = sum[2:0];
        if (!valid && pend[cand]) begin
          valid = 1'b1;
          idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the single sd_card sector-request port among
// up to eight requesters. Optional watchdog enabled by SD_ARB_TIMEOUT_EN.
import sd_pkg::*;

module sd_req_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*32-1:0] req_sector,
  input  logic [NUM_REQ*8-1:0]  req_inbyte,
  output logic [NUM_REQ-1:0]    req_busy,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [NUM_REQ-1:0]    req_outen,
  output logic [8:0]            req_outaddr,
  output logic [7:0]            req_outbyte,
  output logic [7:0]            sd_rstart,
  output logic [7:0]            sd_wstart,
  output logic [31:0]           sd_rsector,
  input  logic                  sd_rbusy,
  input  logic                  sd_rdone,
  input  logic                  sd_outen,
  input  logic [8:0]            sd_outaddr,
  input  logic [7:0]            sd_outbyte,
  output logic [7:0]            sd_inbyte
);

  sd_arb_state_t state, state_next;
  logic [2:0]  gnt, last, pick_idx;
  logic        dir, pick_valid, err_q, tmo_hit;
  logic [SD_MAX_REQ-1:0] pend_full, rd_full;
  logic [31:0] pick_sector;
  logic        unused_bits;

  // Widen request vectors to the full 8 lanes so 3-bit indices are always legal
  always_comb begin
    pend_full = '0;
    rd_full   = '0;
    pend_full[NUM_REQ-1:0] = req_rd | req_wr;
    rd_full[NUM_REQ-1:0]   = req_rd;
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .pend  (pend_full),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the sector of the candidate so it can be captured at grant time
  always_comb begin
    pick_sector = 32'd0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_idx == 3'(i)) pick_sector = req_sector[i*32 +: 32];
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  // Watchdog counts ACTIVE cycles; it is zero on the first ACTIVE cycle
  always_ff @(posedge clk) begin
    if (rst || state != SD_ARB_ACTIVE) tmo_cnt <= 24'd0;
    else                               tmo_cnt <= tmo_cnt + 24'd1;
  end

  assign tmo_hit     = (tmo_cnt == TIMEOUT - 24'd1);
  assign unused_bits = sd_rbusy;
`else
  assign tmo_hit     = 1'b0;
  assign unused_bits = ^{sd_rbusy, TIMEOUT};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SD_ARB_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; sd_rdone takes precedence over the watchdog
  always_comb begin
    state_next = state;
    unique case (state)
      SD_ARB_IDLE:    if (pick_valid) state_next = SD_ARB_ACTIVE;
      SD_ARB_ACTIVE:  if (sd_rdone || tmo_hit) state_next = SD_ARB_RELEASE;
      SD_ARB_RELEASE: state_next = SD_ARB_IDLE;
      default:        state_next = SD_ARB_IDLE;
    endcase
  end

  // Grant bookkeeping: latch winner, direction and sector; record last winner on release
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 3'd0;
      last       <= 3'(NUM_REQ - 1);
      dir        <= 1'b0;
      sd_rsector <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (state == SD_ARB_IDLE && pick_valid) begin
        gnt        <= pick_idx;
        dir        <= !rd_full[pick_idx];
        sd_rsector <= pick_sector;
      end
      if (state == SD_ARB_RELEASE) last <= gnt;
      err_q <= (state == SD_ARB_ACTIVE) && !sd_rdone && tmo_hit;
    end
  end

  // Decode per-requester outputs and start vectors from the registered grant
  always_comb begin
    req_busy  = '0;
    req_done  = '0;
    req_err   = '0;
    req_outen = '0;
    sd_rstart = 8'd0;
    sd_wstart = 8'd0;
    sd_inbyte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == 3'(i)) begin
        req_busy[i]  = (state == SD_ARB_ACTIVE);
        req_done[i]  = (state == SD_ARB_RELEASE);
        req_err[i]   = (state == SD_ARB_RELEASE) && err_q;
        req_outen[i] = sd_outen && (state == SD_ARB_ACTIVE) && !dir;
        sd_rstart[i] = (state == SD_ARB_ACTIVE) && !dir;
        sd_wstart[i] = (state == SD_ARB_ACTIVE) && dir;
        if (state == SD_ARB_ACTIVE) sd_inbyte = req_inbyte[i*8 +: 8];
      end
    end
  end

  assign req_outaddr = sd_outaddr;
  assign req_outbyte = sd_outbyte;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed testbench for sd_req_arbiter (NUM_REQ = 4, TIMEOUT = 100).
module tb_sd_req_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_rd, req_wr;
  logic [N*32-1:0] req_sector;
  logic [N*8-1:0]  req_inbyte;
  logic [N-1:0]  req_busy, req_done, req_err, req_outen;
  logic [8:0]    req_outaddr;
  logic [7:0]    req_outbyte;
  logic [7:0]    sd_rstart, sd_wstart;
  logic [31:0]   sd_rsector;
  logic          sd_rbusy, sd_rdone, sd_outen;
  logic [8:0]    sd_outaddr;
  logic [7:0]    sd_outbyte, sd_inbyte;

  int n_cmp = 0;
  int n_bad = 0;

  sd_req_arbiter #(.NUM_REQ(N), .TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_sector(req_sector), .req_inbyte(req_inbyte),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err), .req_outen(req_outen),
    .req_outaddr(req_outaddr), .req_outbyte(req_outbyte),
    .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_rsector(sd_rsector),
    .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone), .sd_outen(sd_outen),
    .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte), .sd_inbyte(sd_inbyte)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_rd = '0; req_wr = '0; req_sector = '0; req_inbyte = '0;
    sd_rbusy = 1'b0; sd_rdone = 1'b0; sd_outen = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if ({sd_rstart, sd_wstart} !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_starts got %h want 0000", {sd_rstart, sd_wstart}); end
    n_cmp++; if (sd_rsector !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_sector got %h want 0", sd_rsector); end
    n_cmp++; if ({req_busy, req_done, req_err} !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_flags got %h want 000", {req_busy, req_done, req_err}); end
  endtask

  task automatic test_single_read();
    req_sector[31:0] = 32'h0000_1234;
    req_rd[0] = 1'b1;
    tick();
    n_cmp++; if (sd_rstart !== 8'h01) begin n_bad++; $display("[TB] FAIL single_rstart got %h want 01", sd_rstart); end
    n_cmp++; if (sd_rsector !== 32'h0000_1234) begin n_bad++; $display("[TB] FAIL single_sector got %h want 00001234", sd_rsector); end
    n_cmp++; if (req_busy !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_busy got %b want 0001", req_busy); end
    req_sector[31:0] = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (sd_rsector !== 32'h0000_1234) begin n_bad++; $display("[TB] FAIL sector_hold got %h want 00001234", sd_rsector); end
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    req_rd[0] = 1'b0;
    n_cmp++; if (req_done !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_done got %b want 0001", req_done); end
    n_cmp++; if ({sd_rstart, req_busy} !== 12'h000) begin n_bad++; $display("[TB] FAIL single_release got %h want 000", {sd_rstart, req_busy}); end
    tick();
    n_cmp++; if (req_done !== 4'b0000) begin n_bad++; $display("[TB] FAIL done_width got %b want 0000", req_done); end
    tick();
    n_cmp++; if (sd_rstart !== 8'h00) begin n_bad++; $display("[TB] FAIL no_regrant got %h want 00", sd_rstart); end
  endtask

  task automatic test_rr_pair();
    req_rd[1] = 1'b1;
    req_wr[2] = 1'b1;
    tick();
    n_cmp++; if ({sd_rstart, sd_wstart} !== 16'h0200) begin n_bad++; $display("[TB] FAIL pair_first got %h want 0200", {sd_rstart, sd_wstart}); end
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    req_rd[1] = 1'b0;
    n_cmp++; if (req_done !== 4'b0010) begin n_bad++; $display("[TB] FAIL pair_done1 got %b want 0010", req_done); end
    n_cmp++; if ({sd_rstart, sd_wstart} !== 16'h0000) begin n_bad++; $display("[TB] FAIL pair_gap1 got %h want 0000", {sd_rstart, sd_wstart}); end
    tick();
    n_cmp++; if ({sd_rstart, sd_wstart} !== 16'h0000) begin n_bad++; $display("[TB] FAIL pair_gap2 got %h want 0000", {sd_rstart, sd_wstart}); end
    tick();
    n_cmp++; if ({sd_rstart, sd_wstart} !== 16'h0004) begin n_bad++; $display("[TB] FAIL pair_second got %h want 0004", {sd_rstart, sd_wstart}); end
    n_cmp++; if (req_busy !== 4'b0100) begin n_bad++; $display("[TB] FAIL pair_busy got %b want 0100", req_busy); end
    n_cmp++; if (req_outen !== 4'b0000) begin n_bad++; $display("[TB] FAIL pair_outen got %b want 0000", req_outen); end
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    req_wr[2] = 1'b0;
    n_cmp++; if (req_done !== 4'b0100) begin n_bad++; $display("[TB] FAIL pair_done2 got %b want 0100", req_done); end
    tick();
  endtask

  task automatic test_outen();
    int bad_en = 0;
    int bad_addr = 0;
    req_rd[3] = 1'b1;
    tick();
    n_cmp++; if (req_busy !== 4'b1000) begin n_bad++; $display("[TB] FAIL outen_busy got %b want 1000", req_busy); end
    for (int a = 0; a < 512; a++) begin
      sd_outen = 1'b1;
      sd_outaddr = 9'(a);
      sd_outbyte = 8'(a ^ 8'h5A);
      #1;
      n_cmp++; if (req_outen !== 4'b1000) begin n_bad++; bad_en++; if (bad_en < 4) $display("[TB] FAIL outen_on addr %0d got %b want 1000", a, req_outen); end
      n_cmp++; if ({req_outaddr, req_outbyte} !== {9'(a), 8'(a ^ 8'h5A)}) begin n_bad++; bad_addr++; if (bad_addr < 4) $display("[TB] FAIL outaddr got %h want %h", {req_outaddr, req_outbyte}, {9'(a), 8'(a ^ 8'h5A)}); end
      tick();
      sd_outen = 1'b0;
      #1;
      n_cmp++; if (req_outen !== 4'b0000) begin n_bad++; bad_en++; if (bad_en < 4) $display("[TB] FAIL outen_off addr %0d got %b want 0000", a, req_outen); end
    end
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    req_rd[3] = 1'b0;
    n_cmp++; if (req_done !== 4'b1000) begin n_bad++; $display("[TB] FAIL outen_done got %b want 1000", req_done); end
    tick();
  endtask

  task automatic test_inbyte();
    req_inbyte = 32'h0000_A500;
    req_wr[1] = 1'b1;
    n_cmp++; if (sd_inbyte !== 8'h00) begin n_bad++; $display("[TB] FAIL inbyte_idle got %h want 00", sd_inbyte); end
    tick();
    n_cmp++; if (sd_wstart !== 8'h02) begin n_bad++; $display("[TB] FAIL inbyte_wstart got %h want 02", sd_wstart); end
    n_cmp++; if (sd_inbyte !== 8'hA5) begin n_bad++; $display("[TB] FAIL inbyte_active got %h want A5", sd_inbyte); end
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    req_wr[1] = 1'b0;
    n_cmp++; if (sd_inbyte !== 8'h00) begin n_bad++; $display("[TB] FAIL inbyte_release got %h want 00", sd_inbyte); end
    tick();
    req_inbyte = '0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_start [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
    req_rd[0] = 1'b1;
    req_rd[1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++; if (sd_rstart !== exp_start[t]) begin n_bad++; $display("[TB] FAIL b2b_grant%0d got %h want %h", t, sd_rstart, exp_start[t]); end
      sd_rdone = 1'b1;
      tick();
      sd_rdone = 1'b0;
      n_cmp++; if (req_done !== exp_start[t][3:0]) begin n_bad++; $display("[TB] FAIL b2b_done%0d got %b want %b", t, req_done, exp_start[t][3:0]); end
      tick();
    end
    req_rd = '0;
    tick();
  endtask

  task automatic test_rdone_ignored();
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    n_cmp++; if ({req_done, sd_rstart, sd_wstart} !== 20'h00000) begin n_bad++; $display("[TB] FAIL rdone_idle got %h want 00000", {req_done, sd_rstart, sd_wstart}); end
  endtask

  task automatic test_reset_abort();
    req_rd[2] = 1'b1;
    tick();
    n_cmp++; if (sd_rstart !== 8'h04) begin n_bad++; $display("[TB] FAIL abort_start got %h want 04", sd_rstart); end
    rst = 1'b1;
    req_rd[2] = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if ({sd_rstart, req_done, req_busy} !== 16'h0000) begin n_bad++; $display("[TB] FAIL abort_drop got %h want 0000", {sd_rstart, req_done, req_busy}); end
    tick();
    n_cmp++; if (req_done !== 4'b0000) begin n_bad++; $display("[TB] FAIL abort_nodone got %b want 0000", req_done); end
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_rd[0] = 1'b1;
    tick();
    for (int c = 0; c < 99; c++) tick();
    n_cmp++; if (sd_rstart !== 8'h01) begin n_bad++; $display("[TB] FAIL tmo_early got %h want 01", sd_rstart); end
    tick();
    req_rd[0] = 1'b0;
    n_cmp++; if ({req_done, req_err} !== 8'h11) begin n_bad++; $display("[TB] FAIL tmo_pulse got %h want 11", {req_done, req_err}); end
    n_cmp++; if (sd_rstart !== 8'h00) begin n_bad++; $display("[TB] FAIL tmo_drop got %h want 00", sd_rstart); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_rr_pair();
    test_outen();
    test_inbyte();
    test_back_to_back();
    test_rdone_ignored();
    test_reset_abort();
`ifdef SD_ARB_TIMEOUT_EN
    test_reset();
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
